if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RV32I pipeline: PC register, IMEM address drive, and IF/ID pipeline register.

---
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage, PC register plus IF/ID pipeline register.
// Optional perf counters are enabled with `define IF_PERF_CNT_EN.
package if_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;
endpackage

module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall_pc,
  input  logic             i_stall_if_id,
  input  logic             i_flush_if_id,
  input  logic [31:0]      i_pc_target,
  output logic [31:0]      o_imem_addr,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_if_pc,
  output logic [31:0]      o_id_instr,
  output logic [31:0]      o_id_pc,
  output logic [31:0]      o_id_pc4,
  output logic             o_id_valid,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc4;
  if_id_t      if_id_q;

  assign pc4 = pc_q + 32'd4;

  // Redirect target is forced word aligned.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q <= PC_RESET;
    end else if (i_flush_if_id) begin
      pc_q <= {i_pc_target[31:2], 2'b00};
    end else if (!i_stall_pc) begin
      pc_q <= pc4;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      if_id_q.instr <= NOP_INSTR;
      if_id_q.pc    <= '0;
      if_id_q.pc4   <= '0;
      if_id_q.valid <= 1'b0;
    end else if (i_flush_if_id) begin
      if_id_q.instr <= NOP_INSTR;
      if_id_q.valid <= 1'b0;
    end else if (!i_stall_if_id) begin
      if_id_q.instr <= i_imem_rdata;
      if_id_q.pc    <= pc_q;
      if_id_q.pc4   <= pc4;
      if_id_q.valid <= 1'b1;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_if_pc     = pc_q;
  assign o_id_instr  = if_id_q.instr;
  assign o_id_pc     = if_id_q.pc;
  assign o_id_pc4    = if_id_q.pc4;
  assign o_id_valid  = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (i_stall_pc && !i_flush_if_id &&
          stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (i_flush_if_id && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of PC sequencing, stall, flush,
// wrap, async reset and perf counters (CNT_W=4).
module tb_if_stage;

  localparam int CW = 4;
`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall_pc = 1'b0;
  logic          stall_if_id = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   target = '0;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   if_pc;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [31:0]   id_pc4;
  logic          id_valid;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_sc = 0;
  int exp_fc = 0;

  // IMEM word i holds value i.
  assign imem_rdata = {2'b00, imem_addr[31:2]};

  always #5 clk = ~clk;

  if_stage #(.CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_stall_pc(stall_pc),
    .i_stall_if_id(stall_if_id),
    .i_flush_if_id(flush),
    .i_pc_target(target),
    .o_imem_addr(imem_addr),
    .i_imem_rdata(imem_rdata),
    .o_if_pc(if_pc),
    .o_id_instr(id_instr),
    .o_id_pc(id_pc),
    .o_id_pc4(id_pc4),
    .o_id_valid(id_valid),
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (stall_pc && !flush && PERF && exp_sc < 15)
      exp_sc++;
    if (flush && PERF && exp_fc < 15)
      exp_fc++;
  endtask

  // Counter expectation updates must see inputs of the edge just taken,
  // so inputs are only changed after step() returns.
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_sc = 0; exp_fc = 0;
    n_chk++; if (if_pc !== 32'h0) begin n_fail++;
      $display("FAIL rst_pc got %h want 0", if_pc); end
    n_chk++; if (id_instr !== 32'h13) begin n_fail++;
      $display("FAIL rst_instr got %h want 13", id_instr); end
    n_chk++; if (id_pc !== 32'h0 || id_pc4 !== 32'h0) begin n_fail++;
      $display("FAIL rst_idpc got %h/%h want 0/0", id_pc, id_pc4); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid got %b want 0", id_valid); end
    n_chk++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_fail++;
      $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++;
      if (if_pc !== 32'(4*k) || id_pc !== 32'(4*(k-1)) ||
          id_pc4 !== 32'(4*k) || id_instr !== 32'(k-1) ||
          id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq%0d got pc=%h idpc=%h pc4=%h ins=%h v=%b want pc=%h idpc=%h ins=%h v=1",
          k, if_pc, id_pc, id_pc4, id_instr, id_valid, 4*k, 4*(k-1), k-1);
      end
    end
  endtask

  task automatic test_stall();
    stall_pc = 1'b1; stall_if_id = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++;
      if (if_pc !== 32'h10 || id_pc !== 32'hC || id_instr !== 32'h3) begin
        n_fail++;
        $display("FAIL stall%0d got pc=%h idpc=%h ins=%h want 10/c/3",
          k, if_pc, id_pc, id_instr);
      end
    end
    stall_pc = 1'b0; stall_if_id = 1'b0;
    step();
    n_chk++; if (if_pc !== 32'h14 || id_pc !== 32'h10 || id_instr !== 32'h4) begin
      n_fail++; $display("FAIL stall_resume got pc=%h idpc=%h ins=%h want 14/10/4",
        if_pc, id_pc, id_instr); end
    n_chk++; if (stall_cnt !== CW'(exp_sc)) begin n_fail++;
      $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_sc); end
    // Mismatched stalls: PC held, IF/ID loads.
    stall_pc = 1'b1;
    step();
    n_chk++; if (if_pc !== 32'h14 || id_pc !== 32'h14 || id_instr !== 32'h5) begin
      n_fail++; $display("FAIL stall_pc_only got pc=%h idpc=%h ins=%h want 14/14/5",
        if_pc, id_pc, id_instr); end
    stall_pc = 1'b0; stall_if_id = 1'b1;
    step();
    n_chk++; if (if_pc !== 32'h18 || id_pc !== 32'h14 || id_instr !== 32'h5) begin
      n_fail++; $display("FAIL stall_id_only got pc=%h idpc=%h ins=%h want 18/14/5",
        if_pc, id_pc, id_instr); end
    stall_if_id = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1; target = 32'h103;
    step();
    n_chk++; if (if_pc !== 32'h100) begin n_fail++;
      $display("FAIL flush_pc got %h want 100", if_pc); end
    n_chk++; if (id_instr !== 32'h13 || id_valid !== 1'b0 || id_pc !== 32'h14) begin
      n_fail++; $display("FAIL flush_bubble got ins=%h v=%b idpc=%h want 13/0/14",
        id_instr, id_valid, id_pc); end
    flush = 1'b0; target = 32'hDEAD_BEEF;
    step();
    n_chk++; if (if_pc !== 32'h104 || id_pc !== 32'h100 || id_pc4 !== 32'h104 ||
                 id_instr !== 32'h40 || id_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_target got pc=%h idpc=%h pc4=%h ins=%h v=%b want 104/100/104/40/1",
        if_pc, id_pc, id_pc4, id_instr, id_valid); end
  endtask

  task automatic test_flush_stall();
    int sc_before;
    sc_before = exp_sc;
    flush = 1'b1; stall_pc = 1'b1; stall_if_id = 1'b1; target = 32'h40;
    step();
    n_chk++; if (if_pc !== 32'h40 || id_instr !== 32'h13 || id_valid !== 1'b0 ||
                 id_pc !== 32'h100) begin
      n_fail++; $display("FAIL flush_stall got pc=%h ins=%h v=%b idpc=%h want 40/13/0/100",
        if_pc, id_instr, id_valid, id_pc); end
    n_chk++; if (stall_cnt !== CW'(sc_before)) begin n_fail++;
      $display("FAIL flush_stall_cnt got %0d want %0d", stall_cnt, sc_before); end
    flush = 1'b0; stall_pc = 1'b0; stall_if_id = 1'b0;
    step();
    n_chk++; if (if_pc !== 32'h44 || id_pc !== 32'h40 || id_instr !== 32'h10) begin
      n_fail++; $display("FAIL flush_stall_after got pc=%h idpc=%h ins=%h want 44/40/10",
        if_pc, id_pc, id_instr); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; target = 32'hFFFF_FFFE;
    step();
    flush = 1'b0;
    n_chk++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++;
      $display("FAIL wrap_pre got %h want fffffffc", if_pc); end
    step();
    n_chk++; if (if_pc !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 ||
                 id_instr !== 32'h3FFF_FFFF || id_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap got pc=%h idpc=%h pc4=%h ins=%h v=%b want 0/fffffffc/0/3fffffff/1",
        if_pc, id_pc, id_pc4, id_instr, id_valid); end
    n_chk++; if (flush_cnt !== CW'(exp_fc)) begin n_fail++;
      $display("FAIL flush_cnt got %0d want %0d", flush_cnt, exp_fc); end
  endtask

  task automatic test_reset_mid();
    stall_pc = 1'b1; stall_if_id = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    exp_sc = 0; exp_fc = 0;
    n_chk++; if (if_pc !== 32'h0 || id_instr !== 32'h13 || id_valid !== 1'b0 ||
                 id_pc !== 32'h0 || id_pc4 !== 32'h0) begin
      n_fail++; $display("FAIL async_rst got pc=%h ins=%h v=%b idpc=%h pc4=%h want 0/13/0/0/0",
        if_pc, id_instr, id_valid, id_pc, id_pc4); end
    n_chk++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_fail++;
      $display("FAIL async_rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    #1 rst = 1'b0;
    stall_pc = 1'b0; stall_if_id = 1'b0;
    step();
    n_chk++; if (if_pc !== 32'h4 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_rst got pc=%h idpc=%h v=%b want 4/0/1",
        if_pc, id_pc, id_valid); end
  endtask

  task automatic test_perf();
    int want_s;
    int want_f;
    want_s = PERF ? 15 : 0;
    want_f = PERF ? 3 : 0;
    stall_pc = 1'b1;
    repeat (20) step();
    stall_pc = 1'b0;
    n_chk++; if (stall_cnt !== CW'(want_s) || exp_sc != want_s) begin n_fail++;
      $display("FAIL perf_stall_sat got %0d want %0d", stall_cnt, want_s); end
    flush = 1'b1; target = 32'h200;
    repeat (3) step();
    flush = 1'b0;
    step();
    n_chk++; if (flush_cnt !== CW'(want_f)) begin n_fail++;
      $display("FAIL perf_flush got %0d want %0d", flush_cnt, want_f); end
    n_chk++; if (stall_cnt !== CW'(want_s)) begin n_fail++;
      $display("FAIL perf_stall_hold got %0d want %0d", stall_cnt, want_s); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_flush_stall();
    test_wrap();
    test_reset_mid();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
